// File: rtl/ngs_boot_core_irq_ctrl.sv
// Interrupt aggregator: latches up to 16 level/edge irq lines and masks them.
// It drives one registered CPU irq and exposes a 16-bit Avalon-MM register slave.
module ngs_boot_core_irq_ctrl #(
   parameter int unsigned NUM_IRQ   = 8,
   parameter logic [15:0] EDGE_INIT = 16'h0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [15:0]        readdata,
   output logic               irq
);

   typedef enum logic [2:0] {
      REG_PENDING = 3'd0,
      REG_ENABLE  = 3'd1,
      REG_MODE    = 3'd2,
      REG_STATUS  = 3'd3,
      REG_ACTIVE  = 3'd4,
      REG_SWIRQ   = 3'd5,
      REG_RSVD6   = 3'd6,
      REG_RSVD7   = 3'd7
   } reg_addr_e;

   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] enable_q,  enable_d;
   logic [NUM_IRQ-1:0] mode_q,    mode_d;
   logic [NUM_IRQ-1:0] swirq_q,   swirq_d;
   logic [NUM_IRQ-1:0] irq_d_q,   irq_d_d;
   logic [15:0]        readdata_q, readdata_d;
   logic               irq_q,     irq_dn;

   reg_addr_e          addr_e;
   logic               wr;
   logic [NUM_IRQ-1:0] wdata;
   logic [NUM_IRQ-1:0] raw, rise, status, sel_oh, clr, mode_chg;
   logic [3:0]         act_id;
   logic               act_valid;

   function automatic logic [15:0] widen(input logic [NUM_IRQ-1:0] v);
      logic [15:0] r;
      r = '0;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   assign addr_e = reg_addr_e'(address);
   assign wr     = chipselect & ~write_n;
   assign wdata  = writedata[NUM_IRQ-1:0];
   assign raw    = irq_in | swirq_q;
   assign rise   = raw & ~irq_d_q;
   assign status = pending_q & enable_q;

   // Descending scan so the last hit is the lowest index (highest priority).
   always_comb begin
      sel_oh    = '0;
      act_id    = '0;
      act_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (status[NUM_IRQ-1-i]) begin
            sel_oh               = '0;
            sel_oh[NUM_IRQ-1-i]  = 1'b1;
            act_id               = 4'(NUM_IRQ-1-i);
            act_valid            = 1'b1;
         end
      end
   end

   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      swirq_d  = swirq_q;
      clr      = '0;
      if (wr) begin
         case (addr_e)
            REG_PENDING: clr      = wdata;
            REG_ENABLE:  enable_d = wdata;
            REG_MODE:    mode_d   = wdata;
            REG_ACTIVE:  clr      = sel_oh;
            REG_SWIRQ:   swirq_d  = wdata;
            default:     ;
         endcase
      end
      mode_chg = mode_q ^ mode_d;
      irq_d_d  = raw;

      pending_d = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (mode_chg[i])
            pending_d[i] = 1'b0;
         else if (mode_q[i])
            pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
         else
            pending_d[i] = raw[i];
      end

      irq_dn = |status;

      case (addr_e)
         REG_PENDING: readdata_d = widen(pending_q);
         REG_ENABLE:  readdata_d = widen(enable_q);
         REG_MODE:    readdata_d = widen(mode_q);
         REG_STATUS:  readdata_d = widen(status);
         REG_ACTIVE:  readdata_d = {act_valid, 11'b0, act_id};
         REG_SWIRQ:   readdata_d = widen(swirq_q);
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         enable_q   <= '0;
         mode_q     <= EDGE_INIT[NUM_IRQ-1:0];
         swirq_q    <= '0;
         irq_d_q    <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         swirq_q    <= swirq_d;
         irq_d_q    <= irq_d_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_dn;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_ngs_boot_core_irq_ctrl.sv
// Directed self-checking bench for ngs_boot_core_irq_ctrl (NUM_IRQ=8, EDGE_INIT=0x0081).
module tb_ngs_boot_core_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [7:0]  irq_in;
   logic [15:0] readdata;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [15:0] rd_val;

   ngs_boot_core_irq_ctrl #(
      .NUM_IRQ  (8),
      .EDGE_INIT(16'h0081)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .irq_in    (irq_in),
      .readdata  (readdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_rst [8];
      exp_rst = '{16'h0000, 16'h0000, 16'h0081, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      irq_in     = '0;
      tick();
      tick();
      reset_n = 1'b1;

      // 1: reset values
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), rd_val);
         check($sformatf("reset_reg%0d", i), rd_val, exp_rst[i]);
      end
      check("reset_irq", {15'b0, irq}, 16'h0000);

      // 2: edge line 0, W1C
      wr(3'd2, 16'h0001);
      wr(3'd1, 16'h0001);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      check("t2_irq_edge1", {15'b0, irq}, 16'h0000);
      tick();
      check("t2_irq_edge2", {15'b0, irq}, 16'h0001);
      rd(3'd0, rd_val);
      check("t2_pending", rd_val, 16'h0001);
      wr(3'd0, 16'h0001);
      check("t2_irq_after_w1c", {15'b0, irq}, 16'h0001);
      tick();
      check("t2_irq_dropped", {15'b0, irq}, 16'h0000);
      rd(3'd0, rd_val);
      check("t2_pending_clr", rd_val, 16'h0000);

      // 3: level line 3
      wr(3'd2, 16'h0000);
      wr(3'd1, 16'h0008);
      irq_in = 8'h08;
      tick();
      tick();
      check("t3_irq", {15'b0, irq}, 16'h0001);
      rd(3'd3, rd_val);
      check("t3_status", rd_val, 16'h0008);
      wr(3'd0, 16'h0008);
      rd(3'd0, rd_val);
      check("t3_level_ignores_w1c", rd_val, 16'h0008);
      irq_in = 8'h00;
      tick();
      check("t3_irq_1cyc", {15'b0, irq}, 16'h0001);
      tick();
      check("t3_irq_2cyc", {15'b0, irq}, 16'h0000);

      // 4: priority and acknowledge
      wr(3'd2, 16'h0024);
      wr(3'd1, 16'h0024);
      irq_in = 8'h24;
      tick();
      irq_in = 8'h00;
      rd(3'd4, rd_val);
      check("t4_active_first", rd_val, 16'h8002);
      wr(3'd4, 16'h1234);
      check("t4_ack_preedge", readdata, 16'h8002);
      rd(3'd4, rd_val);
      check("t4_active_second", rd_val, 16'h8005);
      wr(3'd4, 16'h0000);
      check("t4_ack2_preedge", readdata, 16'h8005);
      rd(3'd4, rd_val);
      check("t4_active_none", rd_val, 16'h0000);
      check("t4_irq", {15'b0, irq}, 16'h0000);

      // 5: set beats clear; SWIRQ edge sets once
      wr(3'd2, 16'h0012);
      wr(3'd1, 16'h0002);
      irq_in = 8'h02;
      tick();
      irq_in = 8'h00;
      tick();
      address    = 3'd0;
      writedata  = 16'h0002;
      chipselect = 1'b1;
      write_n    = 1'b0;
      irq_in     = 8'h02;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      irq_in     = 8'h00;
      rd(3'd0, rd_val);
      check("t5_set_beats_clr", rd_val, 16'h0002);
      wr(3'd0, 16'h0002);
      rd(3'd0, rd_val);
      check("t5_plain_clr", rd_val, 16'h0000);
      wr(3'd1, 16'h0010);
      wr(3'd5, 16'h0010);
      tick();
      check("t5_swirq_irq_early", {15'b0, irq}, 16'h0000);
      tick();
      check("t5_swirq_irq", {15'b0, irq}, 16'h0001);
      rd(3'd0, rd_val);
      check("t5_swirq_pending", rd_val, 16'h0010);
      wr(3'd0, 16'h0010);
      tick();
      rd(3'd0, rd_val);
      check("t5_swirq_once", rd_val, 16'h0000);
      rd(3'd5, rd_val);
      check("t5_swirq_reg", rd_val, 16'h0010);

      // 6: async reset mid-operation
      wr(3'd2, 16'h0000);
      wr(3'd1, 16'hFFFF);
      rd(3'd1, rd_val);
      check("t6_enable_width", rd_val, 16'h00FF);
      wr(3'd5, 16'h00FF);
      tick();
      tick();
      rd(3'd0, rd_val);
      check("t6_pending_ff", rd_val, 16'h00FF);
      check("t6_irq_high", {15'b0, irq}, 16'h0001);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_irq_async", {15'b0, irq}, 16'h0000);
      check("t6_rdata_async", readdata, 16'h0000);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), rd_val);
         check($sformatf("t6_reg%0d", i), rd_val, exp_rst[i]);
      end
      check("t6_irq_after", {15'b0, irq}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
